// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter
// Round-robin arbiter that shares one WIDTH-bit register between N_REQ
// requesters. A winner is granted for one cycle, its data is captured on
// the following edge and presented downstream with a valid/ack handshake.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   req      - per-requester request, held until granted
//   din      - per-requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt      - registered one-hot grant, one cycle per grant
//   q        - shared register contents
//   q_valid  - q holds unconsumed data
//   q_owner  - index of the requester whose data is in q
//   q_ack    - consumer accepts q
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant outstanding; arbitrate when the slot is free
// GRANT | gnt high for granted index; load its data if req still held
module dff_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [PW-1:0]          q_owner,
    input  logic                   q_ack
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t              state, state_next;
    logic [PW-1:0]       rr_ptr, rr_ptr_next;
    logic [PW-1:0]       g_idx, g_idx_next;
    logic [N_REQ-1:0]    gnt_next;
    logic [WIDTH-1:0]    q_next;
    logic                q_valid_next;
    logic [PW-1:0]       q_owner_next;

    logic                slot_free;
    logic                found;
    logic [PW-1:0]       win;
    logic [PW-1:0]       cand;
    logic [WIDTH-1:0]    g_data;
    int                  idx;

    // Slot counts as free when the consumer drains it in the same cycle.
    assign slot_free = !q_valid || q_ack;

    // First set request at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Only the granted requester's data is ever routed to the register.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g_idx == PW'(i)) begin
                g_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        g_idx_next   = g_idx;
        gnt_next     = '0;
        q_next       = q;
        q_valid_next = q_valid;
        q_owner_next = q_owner;

        if (q_valid && q_ack) begin
            q_valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (slot_free && found) begin
                    gnt_next[win] = 1'b1;
                    g_idx_next    = win;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                state_next = IDLE;
                // A dropped request aborts: nothing loads, pointer holds.
                if (req[g_idx]) begin
                    q_next       = g_data;
                    q_valid_next = 1'b1;
                    q_owner_next = g_idx;
                    rr_ptr_next  = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            g_idx   <= '0;
            gnt     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            q_owner <= '0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            g_idx   <= g_idx_next;
            gnt     <= gnt_next;
            q       <= q_next;
            q_valid <= q_valid_next;
            q_owner <= q_owner_next;
        end
    end

endmodule
